mac_seq_ctrl: RTL and testbench

Sequencer for the bit-split MAC datapath: accepts one job (weight, activation count, initial psum, precision mode) and streams activations through a single weight-stationary MAC. It accumulates the partial sum locally and returns one result per job over a valid/ready handshake. It sits between the activation/weight SRAM readers and the psum writeback path. The MAC arithmetic is implemented inside the block; it is not an external instance.

---
 rtl/mac_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for a weight-stationary bit-split MAC: loads one weight, streams
// activations into a local accumulator and hands back one psum per job.
module mac_seq_ctrl #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 24,
    parameter int LW      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_act_mode,
    input  logic [LW-1:0]      cfg_len,
    input  logic [PSUM_BW-1:0] cfg_psum,
    input  logic               abort,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [BW-1:0]      w_data,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [BW-1:0]      a_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PSUM_BW-1:0] out_psum,
    output logic               act_mode,
    output logic               busy,
    output logic [LW-1:0]      a_count
);

    localparam int HB = BW / 2;
    localparam int HP = PSUM_BW / 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [PSUM_BW-1:0] acc;
    logic [PSUM_BW-1:0] acc_mac;
    logic [BW-1:0]      w_reg;
    logic [LW-1:0]      len_reg;
    logic [LW-1:0]      a_count_inc;

    logic signed [PSUM_BW-1:0] w_full, a_full, prod_full;
    logic signed [HP-1:0]      w_half, a_lo, a_hi, prod_lo, prod_hi;

    assign a_count_inc = a_count + LW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort overrides every state, including a start arriving in IDLE
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:   if (start) state_next = (cfg_len == '0) ? DONE : LOAD_W;
                LOAD_W: if (w_valid) state_next = RUN;
                RUN:    if (a_valid && (a_count_inc == len_reg)) state_next = DONE;
                DONE:   if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Activations are unsigned, so they are zero-extended before the signed multiply;
    // split mode keeps two independent lanes with no carry between them.
    always_comb begin
        w_full    = PSUM_BW'($signed(w_reg));
        a_full    = PSUM_BW'(a_data);
        prod_full = a_full * w_full;
        w_half    = HP'($signed(w_reg));
        a_lo      = HP'(a_data[HB-1:0]);
        a_hi      = HP'(a_data[BW-1:HB]);
        prod_lo   = a_lo * w_half;
        prod_hi   = a_hi * w_half;
        if (act_mode) begin
            acc_mac = {acc[PSUM_BW-1:HP] + prod_hi, acc[HP-1:0] + prod_lo};
        end else begin
            acc_mac = acc + prod_full;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            a_count  <= '0;
            act_mode <= 1'b0;
            len_reg  <= '0;
            w_reg    <= '0;
        end else if (abort) begin
            acc     <= '0;
            a_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= cfg_psum;
                        a_count  <= '0;
                        act_mode <= cfg_act_mode;
                        len_reg  <= cfg_len;
                    end
                end
                LOAD_W: begin
                    if (w_valid) w_reg <= w_data;
                end
                RUN: begin
                    if (a_valid) begin
                        acc     <= acc_mac;
                        a_count <= a_count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_ready   = (state == LOAD_W);
    assign a_ready   = (state == RUN);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_psum  = acc;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized scoreboard bench for mac_seq_ctrl: a driver issues jobs and queues
// reference psums, a negedge monitor checks every presented result against the queue.
module tb_mac_seq_ctrl;

    localparam int BW      = 4;
    localparam int PSUM_BW = 24;
    localparam int LW      = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               cfg_act_mode;
    logic [LW-1:0]      cfg_len;
    logic [PSUM_BW-1:0] cfg_psum;
    logic               abort;
    logic               w_valid;
    logic               w_ready;
    logic [BW-1:0]      w_data;
    logic               a_valid;
    logic               a_ready;
    logic [BW-1:0]      a_data;
    logic               out_valid;
    logic               out_ready;
    logic [PSUM_BW-1:0] out_psum;
    logic               act_mode;
    logic               busy;
    logic [LW-1:0]      a_count;

    int n_checks = 0;
    int n_fail   = 0;

    int                 acts_q[$];
    logic [PSUM_BW-1:0] exp_q[$];

    mac_seq_ctrl #(.BW(BW), .PSUM_BW(PSUM_BW), .LW(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_act_mode(cfg_act_mode),
        .cfg_len(cfg_len), .cfg_psum(cfg_psum), .abort(abort),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
        .act_mode(act_mode), .busy(busy), .a_count(a_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: plain integer sums of activation*weight, wrapped to the psum or lane width
    function automatic logic [PSUM_BW-1:0] model(input bit mode, input logic [PSUM_BW-1:0] psum,
                                                 input logic [BW-1:0] w, input int n);
        int ws;
        longint s;
        int lo, hi;
        logic [11:0] lo12, hi12;
        ws = (w >= 8) ? int'(w) - 16 : int'(w);
        if (!mode) begin
            s = longint'(psum);
            for (int i = 0; i < n; i++) s += longint'(acts_q[i] * ws);
            return PSUM_BW'(s);
        end
        lo = int'(psum) % 4096;
        hi = int'(psum) / 4096;
        for (int i = 0; i < n; i++) begin
            lo += (acts_q[i] % 4) * ws;
            hi += (acts_q[i] / 4) * ws;
        end
        lo12 = 12'(lo);
        hi12 = 12'(hi);
        return {hi12, lo12};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        acts_q.delete();
        for (int i = 0; i < n; i++) acts_q.push_back(int'($urandom_range(0, 15)));
    endtask

    // Runs one job; abort_at / reset_at >= 0 cut the job short before that activation
    task automatic apply_stimulus(input bit mode, input int len, input logic [PSUM_BW-1:0] psum,
                                  input logic [BW-1:0] w, input int gap_max, input int stall,
                                  input int abort_at, input int reset_at);
        int gap;
        for (int t = 0; t < 50 && busy; t++) tick();
        check_output("idle_before_start", busy, 0);
        if (abort_at < 0 && reset_at < 0) exp_q.push_back(model(mode, psum, w, len));
        start        = 1'b1;
        cfg_act_mode = mode;
        cfg_len      = LW'(len);
        cfg_psum     = psum;
        tick();
        start        = 1'b0;
        cfg_act_mode = 1'($urandom);
        cfg_len      = LW'($urandom);
        cfg_psum     = PSUM_BW'($urandom);
        check_output("act_mode_latched", act_mode, mode);
        if (len == 0) begin
            check_output("zero_len_out_valid", out_valid, 1);
            check_output("zero_len_w_ready", w_ready, 0);
        end else begin
            check_output("w_ready_after_start", w_ready, 1);
            w_valid = 1'b1;
            w_data  = w;
            for (int t = 0; t < 50 && !w_ready; t++) tick();
            tick();
            w_valid = 1'b0;
            w_data  = BW'($urandom);
            check_output("a_ready_after_weight", a_ready, 1);
            for (int i = 0; i < len; i++) begin
                if (i == abort_at) begin
                    abort   = 1'b1;
                    a_valid = 1'b1;
                    a_data  = BW'(acts_q[i]);
                    start   = 1'b1;
                    tick();
                    abort   = 1'b0;
                    a_valid = 1'b0;
                    start   = 1'b0;
                    check_output("abort_busy", busy, 0);
                    check_output("abort_a_count", a_count, 0);
                    check_output("abort_out_psum", out_psum, 0);
                    repeat (2) tick();
                    check_output("abort_stays_idle", {busy, out_valid}, 0);
                    return;
                end
                if (i == reset_at) begin
                    #2 reset = 1'b1;
                    #1;
                    check_output("async_reset_outputs",
                                 {w_ready, a_ready, out_valid, busy, act_mode, a_count, out_psum}, 0);
                    tick();
                    reset = 1'b0;
                    return;
                end
                gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
                repeat (gap) tick();
                a_valid = 1'b1;
                a_data  = BW'(acts_q[i]);
                for (int t = 0; t < 50 && !a_ready; t++) tick();
                tick();
                a_valid = 1'b0;
                a_data  = BW'($urandom);
            end
            check_output("out_valid_after_last_act", out_valid, 1);
            check_output("a_count_final", a_count, 32'(len));
        end
        for (int k = 0; k < stall; k++) begin
            if (k == 1) begin
                start    = 1'b1;
                cfg_len  = '0;
                cfg_psum = 24'hABCDEF;
            end
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        for (int t = 0; t < 50 && !out_valid; t++) tick();
        check_output("out_valid_wait", out_valid, 1);
        tick();
        out_ready = 1'b0;
        check_output("out_valid_drop", out_valid, 0);
    endtask

    // Monitor: every cycle with out_valid is compared against the oldest queued result
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_out_valid", out_valid, 0);
            end else begin
                check_output("out_psum", out_psum, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int len, abort_at;
        reset = 1'b1; start = 1'b0; cfg_act_mode = 1'b0; cfg_len = '0; cfg_psum = '0;
        abort = 1'b0; w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        check_output("reset_outputs",
                     {w_ready, a_ready, out_valid, busy, act_mode, a_count, out_psum}, 0);
        reset = 1'b0;
        tick();

        acts_q = '{5, 15, 2};
        apply_stimulus(1'b0, 3, 24'd10, 4'b1101, 0, 0, -1, -1);
        acts_q = '{14, 5};
        apply_stimulus(1'b1, 2, 24'd0, 4'd3, 0, 0, -1, -1);
        acts_q = '{1};
        apply_stimulus(1'b1, 1, 24'h000FFF, 4'd1, 0, 0, -1, -1);
        apply_stimulus(1'b0, 1, 24'h000FFF, 4'd1, 0, 0, -1, -1);
        apply_stimulus(1'b0, 0, 24'h123456, 4'd0, 0, 0, -1, -1);
        acts_q = '{5, 15, 2};
        apply_stimulus(1'b0, 3, 24'd10, 4'b1101, 0, 5, -1, -1);
        apply_stimulus(1'b0, 3, 24'd10, 4'b1101, 2, 0, -1, -1);
        fill_random(4);
        apply_stimulus(1'b0, 4, 24'h000321, 4'd7, 0, 0, 2, -1);
        acts_q = '{5, 15, 2};
        apply_stimulus(1'b0, 3, 24'd10, 4'b1101, 0, 0, -1, -1);
        fill_random(4);
        apply_stimulus(1'b1, 4, 24'h0F0F0F, 4'd6, 0, 0, -1, 2);
        tick();

        for (int j = 0; j < 30; j++) begin
            len = int'($urandom_range(0, 12));
            fill_random(len);
            abort_at = (len > 1 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            apply_stimulus(1'($urandom), len, PSUM_BW'($urandom), BW'($urandom),
                           int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), abort_at, -1);
        end

        repeat (3) tick();
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
